// File: rtl/ram_dump_reader.sv
// Sequential RAM readback engine: reads word_count words from start_addr and streams them out on valid/ready.
// Optional running checksum of the streamed words is built only when DUMP_CHECKSUM_EN is defined.
module ram_dump_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              rd_select,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, FIN} state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
    logic [ADDR_W:0]     count_reg, count_next;
    logic [DATA_W-1:0]   dout_reg, dout_next;
    logic [ADDR_W-1:0]   dout_addr_reg, dout_addr_next;
    logic                dout_valid_reg, dout_valid_next;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= IDLE;
            ram_addr_reg   <= '0;
            count_reg      <= '0;
            dout_reg       <= '0;
            dout_addr_reg  <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ram_addr_reg   <= ram_addr_next;
            count_reg      <= count_next;
            dout_reg       <= dout_next;
            dout_addr_reg  <= dout_addr_next;
            dout_valid_reg <= dout_valid_next;
        end
    end

    // ram_addr_reg doubles as the current word address; it only advances when another read follows,
    // so in IDLE the RAM still sees the last address actually read.
    always_comb begin
        state_next      = state_reg;
        ram_addr_next   = ram_addr_reg;
        count_next      = count_reg;
        dout_next       = dout_reg;
        dout_addr_next  = dout_addr_reg;
        dout_valid_next = dout_valid_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        state_next = FIN;
                    end else begin
                        ram_addr_next = start_addr;
                        count_next    = word_count;
                        state_next    = ISSUE;
                    end
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                dout_next       = ram_q;
                dout_addr_next  = ram_addr_reg;
                dout_valid_next = 1'b1;
                state_next      = HOLD;
            end
            HOLD: begin
                if (dout_valid_reg && dout_ready) begin
                    dout_valid_next = 1'b0;
                    count_next      = count_reg - CNT_ONE;
                    if (count_reg == CNT_ONE) begin
                        state_next = FIN;
                    end else begin
                        ram_addr_next = ram_addr_reg + ADDR_ONE;
                        state_next    = ISSUE;
                    end
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ram_addr   = ram_addr_reg;
    assign ram_rden   = (state_reg == ISSUE);
    assign done       = (state_reg == FIN);
    assign busy       = (state_reg != IDLE);
    assign rd_select  = busy;
    assign dout       = dout_reg;
    assign dout_addr  = dout_addr_reg;
    assign dout_valid = dout_valid_reg;

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_reg;
    logic              accept;
    logic              handshake;

    assign accept    = (state_reg == IDLE) && start;
    assign handshake = (state_reg == HOLD) && dout_valid_reg && dout_ready;

    always_ff @(posedge Clk) begin
        if (Reset || accept) begin
            checksum_reg <= '0;
        end else if (handshake) begin
            checksum_reg <= checksum_reg + dout_reg;
        end
    end

    assign checksum = checksum_reg;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_dump_reader.sv
// Directed bench for ram_dump_reader: table of dump scenarios against a behavioural RAM, plus a reset-abort sequence.
module tb_ram_dump_reader;

    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW:0]   wc;
        int            stall_word;
        int            stall_len;
        int            restart_cycle;
        int            exp_first;
        int            exp_done;
    } vec_t;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          rd_select;
    logic [AW-1:0] ram_addr;
    logic          ram_rden;
    logic [DW-1:0] ram_q = '0;
    logic [DW-1:0] dout;
    logic [AW-1:0] dout_addr;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem [1024];
    vec_t          vecs [7];

    ram_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .start_addr(start_addr),
        .word_count(word_count), .rd_select(rd_select), .ram_addr(ram_addr),
        .ram_rden(ram_rden), .ram_q(ram_q), .dout(dout), .dout_addr(dout_addr),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
        .done(done), .checksum(checksum)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (ram_rden) ram_q <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " rd_select"}, rd_select, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " ram_rden"}, ram_rden, 0);
        chk({tag, " dout_valid"}, dout_valid, 0);
        chk({tag, " ram_addr"}, ram_addr, 0);
        chk({tag, " dout"}, dout, 0);
        chk({tag, " dout_addr"}, dout_addr, 0);
        chk({tag, " checksum"}, checksum, 0);
    endtask

    // Cycle c counts from 1 = the cycle after the edge that accepts start.
    task automatic run_dump(input vec_t v, input string name);
        int            widx = 0;
        int            rd_idx = 0;
        int            stall_cnt = 0;
        int            first_valid = -1;
        int            done_cyc = -1;
        logic [DW-1:0] sum = '0;
        logic [DW-1:0] exp_sum;
        logic [DW-1:0] exp_d;
        logic [AW-1:0] ea;
        @(negedge Clk);
        start_addr = v.sa; word_count = v.wc; start = 1'b1; dout_ready = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        for (int c = 1; c <= 4000; c++) begin
            if (ram_rden) begin
                ea = v.sa + rd_idx[AW-1:0];
                chk({name, " ram_addr"}, ram_addr, ea);
                chk({name, " rden_while_valid"}, dout_valid, 0);
                rd_idx++;
            end
            if (done) begin
                done_cyc = c;
                chk({name, " rd_select_at_done"}, rd_select, 1);
                break;
            end
            if (dout_valid) begin
                if (first_valid < 0) first_valid = c;
                ea = v.sa + widx[AW-1:0];
                exp_d = 32'hA500_0000 + 32'(ea);
                chk({name, " dout_addr"}, dout_addr, ea);
                chk({name, " dout"}, dout, exp_d);
                if (widx == v.stall_word && stall_cnt < v.stall_len) begin
                    dout_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    dout_ready = 1'b1;
                    sum = sum + exp_d;
                    widx++;
                end
            end else begin
                dout_ready = 1'($urandom_range(0, 1));
            end
            start = (c == v.restart_cycle);
            if (start) begin
                start_addr = 10'h155;
                word_count = 11'd2;
            end
            @(negedge Clk);
        end
        start = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        exp_sum = sum;
`else
        exp_sum = '0;
`endif
        chk({name, " words"}, widx, v.wc);
        chk({name, " rden_count"}, rd_idx, v.wc);
        chk({name, " first_valid_cycle"}, first_valid, v.exp_first);
        chk({name, " done_cycle"}, done_cyc, v.exp_done);
        chk({name, " checksum"}, checksum, exp_sum);
        @(negedge Clk);
        chk({name, " done_after"}, done, 0);
        chk({name, " busy_after"}, busy, 0);
        chk({name, " rd_select_after"}, rd_select, 0);
        chk({name, " valid_after"}, dout_valid, 0);
        chk({name, " checksum_hold"}, checksum, exp_sum);
        $display("dump %s sa=0x%03h wc=%0d words=%0d done_cycle=%0d checksum=0x%08h",
                 name, v.sa, v.wc, widx, done_cyc, checksum);
    endtask

    initial begin
        int   hit;
        int   saw_done;
        vec_t v;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 + 32'(i);

        vecs[0] = '{10'h000, 11'd4,    -1, 0, 0,  3, 13};
        vecs[1] = '{10'h010, 11'd4,     1, 5, 0,  3, 18};
        vecs[2] = '{10'h3FE, 11'd3,    -1, 0, 0,  3, 10};
        vecs[3] = '{10'h100, 11'd0,    -1, 0, 0, -1,  1};
        vecs[4] = '{10'h020, 11'd5,    -1, 0, 5,  3, 16};
        vecs[5] = '{10'h005, 11'd1024, -1, 0, 0,  3, 3073};
        vecs[6] = '{10'h3FF, 11'd1,    -1, 0, 0,  3,  4};

        repeat (3) @(negedge Clk);
        check_reset_outputs("reset");
        Reset = 1'b0;
        @(negedge Clk);
        check_reset_outputs("idle");

        for (int i = 0; i < 7; i++) run_dump(vecs[i], $sformatf("vec%0d", i));

        // Abort an 8-word dump while word 2 is being held.
        @(negedge Clk);
        start_addr = 10'h040; word_count = 11'd8; start = 1'b1; dout_ready = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        hit = 0;
        saw_done = 0;
        for (int c = 0; c < 100 && hit == 0; c++) begin
            if (done) saw_done = 1;
            if (dout_valid && dout_addr == 10'h042) begin
                hit = 1;
                dout_ready = 1'b0;
                Reset = 1'b1;
            end else begin
                @(negedge Clk);
            end
        end
        chk("abort reached_hold2", hit, 1);
        @(negedge Clk);
        check_reset_outputs("abort");
        Reset = 1'b0;
        dout_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            if (done) saw_done = 1;
        end
        chk("abort no_done", saw_done, 0);
        chk("abort idle_busy", busy, 0);
        $display("abort reset_in_hold2 reached=%0d done_seen=%0d", hit, saw_done);

        v = '{10'h040, 11'd8, -1, 0, 0, 3, 25};
        run_dump(v, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
